// File: rtl/reset_sequencer.sv
// ============================================================================
//  Module      : reset_sequencer
//  Description : Ordered, synchronously released, active-high subdomain
//                resets with software restart path, ready flag and
//                last-reset-cause register.
//                Optional watchdog: define RESET_SEQUENCER_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGES      = 3,
  parameter int STAGE_GAP   = 4,
  parameter int WDT_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_rst_req,
  input  logic              wdt_kick,
  output logic [STAGES-1:0] rst_out,
  output logic              ready,
  output logic [1:0]        cause
);

  localparam int MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_ALL = (MAX_HG > WDT_TIMEOUT) ? MAX_HG : WDT_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;
  localparam int IDX_W   = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(STAGES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  localparam logic [1:0] CAUSE_EXT = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;

`ifdef RESET_SEQUENCER_WATCHDOG_EN
  localparam logic [1:0]       CAUSE_WDT = 2'b10;
  localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_TIMEOUT - 1);
`else
  // Watchdog service input has no function in this build.
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
`endif

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;     // hold / gap / watchdog counter
  logic [IDX_W-1:0]    idx, idx_nxt;     // next stage to release
  logic [STAGES-1:0]   rst_nxt;
  logic                ready_nxt;
  logic [1:0]          cause_nxt;

  // The FSM state register acts as the final synchronizer flop, so the
  // explicit chain holds SYNC_STAGES-1 flops; HOLD is entered on the edge
  // where the deassertion has passed SYNC_STAGES flops in total.
  logic [SYNC_STAGES-2:0] sync_chain;

  generate
    if (SYNC_STAGES == 2) begin : g_sync_single
      // Single explicit synchronizer flop captures the released reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_chain <= '0;
        else        sync_chain <= 1'b1;
      end
    end else begin : g_sync_multi
      // Shift a one through the synchronizer chain after reset release.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_chain <= '0;
        else        sync_chain <= {sync_chain[SYNC_STAGES-3:0], 1'b1};
      end
    end
  endgenerate

  // State and output registers; reset assertion is immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SYNC;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      cause   <= CAUSE_EXT;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      rst_out <= rst_nxt;
      ready   <= ready_nxt;
      cause   <= cause_nxt;
    end
  end

  // Next-state, counter and output sequencing.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rst_nxt   = rst_out;
    ready_nxt = ready;
    cause_nxt = cause;

    case (state)
      SYNC: begin
        if (sync_chain[SYNC_STAGES-2]) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end

      HOLD: begin
        if (cnt == HOLD_LAST) begin
          // Stage 0 is released on the HOLD exit edge itself.
          rst_nxt[0] = 1'b0;
          cnt_nxt    = '0;
          if (STAGES == 1) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
            idx_nxt   = '0;
          end else begin
            state_nxt = RELEASE;
            idx_nxt   = IDX_ONE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      RELEASE: begin
        if (cnt == GAP_LAST) begin
          rst_nxt[idx] = 1'b0;
          cnt_nxt      = '0;
          if (idx == IDX_LAST) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      RUN: begin
        // Software request outranks watchdog expiry; a kick outranks expiry.
        if (sw_rst_req) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          rst_nxt   = '1;
          ready_nxt = 1'b0;
          cause_nxt = CAUSE_SW;
        end
`ifdef RESET_SEQUENCER_WATCHDOG_EN
        else if (wdt_kick) begin
          cnt_nxt = '0;
        end else if (cnt == WDT_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          rst_nxt   = '1;
          ready_nxt = 1'b0;
          cause_nxt = CAUSE_WDT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end

      default: begin
        state_nxt = SYNC;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Self-checking bench for reset_sequencer. Expected outputs
//                come from an edge-arithmetic model: stage k releases at
//                edge (origin + k*STAGE_GAP), restarts move the origin.
//                Watchdog scenarios run when RESET_SEQUENCER_WATCHDOG_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

  localparam int SYNC_STAGES = 2;
  localparam int HOLD_CYCLES = 16;
  localparam int STAGES      = 3;
  localparam int STAGE_GAP   = 4;
  localparam int WDT_TIMEOUT = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              sw_rst_req = 1'b0;
  logic              wdt_kick = 1'b0;
  logic [STAGES-1:0] rst_out;
  logic              ready;
  logic [1:0]        cause;

  int total = 0;
  int bad   = 0;

  // Model state: edges since release, edge where stage 0 releases, cause.
  int         edge_n  = 0;
  int         clr0    = SYNC_STAGES + HOLD_CYCLES;
  logic [1:0] m_cause = 2'b00;
  int         last_wd = 0;

  reset_sequencer #(
    .SYNC_STAGES (SYNC_STAGES),
    .HOLD_CYCLES (HOLD_CYCLES),
    .STAGES      (STAGES),
    .STAGE_GAP   (STAGE_GAP),
    .WDT_TIMEOUT (WDT_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req),
    .wdt_kick   (wdt_kick),
    .rst_out    (rst_out),
    .ready      (ready),
    .cause      (cause)
  );

  always #5 clk = ~clk;

  function automatic int run_edge();
    return clr0 + (STAGES - 1) * STAGE_GAP;
  endfunction

  task automatic check(input string tag);
    logic [STAGES-1:0] exp_rst;
    logic              exp_ready;
    for (int k = 0; k < STAGES; k++) exp_rst[k] = (edge_n < clr0 + k * STAGE_GAP);
    exp_ready = (edge_n >= run_edge());
    total++;
    assert (rst_out === exp_rst) else begin
      bad++;
      $error("FAIL %s rst_out: got %b want %b (edge %0d)", tag, rst_out, exp_rst, edge_n);
    end
    total++;
    assert (ready === exp_ready) else begin
      bad++;
      $error("FAIL %s ready: got %b want %b (edge %0d)", tag, ready, exp_ready, edge_n);
    end
    total++;
    assert (cause === m_cause) else begin
      bad++;
      $error("FAIL %s cause: got %b want %b (edge %0d)", tag, cause, m_cause, edge_n);
    end
  endtask

  // One clock edge with the given inputs, model update, then check.
  task automatic tick(input logic sw, input logic kick, input string tag);
    bit running;
    sw_rst_req = sw;
    wdt_kick   = kick;
    @(posedge clk);
    edge_n++;
    running = ((edge_n - 1) >= run_edge());
    if (running) begin
      if (sw) begin
        clr0    = edge_n + HOLD_CYCLES;
        m_cause = 2'b01;
      end
`ifdef RESET_SEQUENCER_WATCHDOG_EN
      else if (kick) begin
        last_wd = edge_n;
      end else if (edge_n - last_wd == WDT_TIMEOUT) begin
        clr0    = edge_n + HOLD_CYCLES;
        m_cause = 2'b10;
      end
`endif
    end
    if (edge_n == run_edge()) last_wd = edge_n;
    #1;
    check(tag);
  endtask

  // Assert rst_n between edges, hold it, then release mid-cycle.
  task automatic async_reset(input int hold);
    #3;
    rst_n      = 1'b0;
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;
    edge_n     = 0;
    clr0       = SYNC_STAGES + HOLD_CYCLES;
    m_cause    = 2'b00;
    #1;
    check("async_assert");
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("in_reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance until ready, bounded; an expired bound is a failure.
  task automatic wait_run();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick(1'b0, 1'b0, "wait_run");
      n++;
    end
    total++;
    assert (ready === 1'b1) else begin
      bad++;
      $error("FAIL wait_run timeout: ready got %b want 1", ready);
    end
  endtask

  initial begin
    // Power-on reset for 5 cycles, release mid-cycle, full sequence.
    #2;
    async_reset(5);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, "por_seq");

    // Asynchronous assertion while in RUN, then full sequence again.
    async_reset(3);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, "run_async");

    // Asynchronous assertion mid-sequence (during HOLD).
    async_reset(2);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, "pre_mid");
    async_reset(2);

    // Software requests during HOLD (edge 10) and RELEASE (edge 20) ignored.
    for (int i = 1; i <= 30; i++)
      tick((i == 10 || i == 20 || i == 24), 1'b0, "sw_ignored");

    // One-cycle software request in RUN.
    wait_run();
    tick(1'b0, 1'b0, "run_idle");
    tick(1'b1, 1'b0, "sw_pulse");
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, "sw_seq");

    // Randomized software requests and kicks.
    for (int i = 0; i < 300; i++)
      tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), "random");

`ifdef RESET_SEQUENCER_WATCHDOG_EN
    // No kicks: expiry on the 32nd RUN cycle.
    wait_run();
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, "wdt_expire");
    // Kicks every 20 cycles: no reset for 500 cycles.
    wait_run();
    for (int i = 1; i <= 500; i++) tick(1'b0, (i % 20 == 0), "wdt_kicked");
    // Software request coincident with expiry: software wins.
    wait_run();
    for (int i = 0; i < 31; i++) tick(1'b0, 1'b0, "wdt_pre_sw");
    tick(1'b1, 1'b0, "wdt_sw_coinc");
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, "wdt_sw_seq");
    // Kick coincident with expiry: kick wins.
    wait_run();
    for (int i = 0; i < 31; i++) tick(1'b0, 1'b0, "wdt_pre_kick");
    tick(1'b0, 1'b1, "wdt_kick_coinc");
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, "wdt_after_kick");
`else
    // Without the watchdog, kicks are ignored and RUN persists.
    wait_run();
    for (int i = 0; i < 100; i++) tick(1'b0, ($urandom_range(0, 3) == 0), "no_wdt");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
